// File: rtl/top_pkg.sv
// Shared widths, receiver state type and the A-law / Hamming(12,8) helpers.
package top_pkg;

  localparam int unsigned FrameW = 16;
  localparam int unsigned CodeW  = 12;

  typedef enum logic [0:0] {StHunt, StLock} rx_state_e;

  // Sample is offset-binary; the linear value is (sample-128)*32, sign bit set for x >= 0.
  function automatic logic [7:0] alaw_encode(input logic [7:0] sample);
    logic [12:0] x;
    logic [12:0] mag;
    logic [11:0] m;
    logic [2:0]  seg;
    logic [3:0]  mant;
    x    = {~sample[7], sample[6:0], 5'b0};
    mag  = x[12] ? 13'(-x) : x;
    m    = mag[12] ? 12'hfff : mag[11:0];
    seg  = 3'd0;
    mant = m[4:1];
    // Ascending scan: the highest set bit is the last one to win.
    for (int i = 5; i < 12; i++) begin
      if (m[i]) begin
        seg  = 3'(i - 4);
        mant = 4'(m >> (i - 4));
      end
    end
    return {sample[7], seg, mant};
  endfunction

  // Bit i of the codeword is position i+1; data sits at positions 3,5,6,7,9,10,11,12.
  function automatic logic [11:0] hamming_encode(input logic [7:0] d);
    logic [11:0] cw;
    cw     = '0;
    cw[2]  = d[0];
    cw[4]  = d[1];
    cw[5]  = d[2];
    cw[6]  = d[3];
    cw[8]  = d[4];
    cw[9]  = d[5];
    cw[10] = d[6];
    cw[11] = d[7];
    cw[0]  = ^(cw & 12'h555);
    cw[1]  = ^(cw & 12'h666);
    cw[3]  = ^(cw & 12'h878);
    cw[7]  = ^(cw & 12'hf80);
    return cw;
  endfunction

  function automatic logic [3:0] hamming_syndrome(input logic [11:0] cw);
    logic [3:0] syn;
    syn = '0;
    for (int i = 0; i < 12; i++) begin
      if (cw[i]) syn = syn ^ 4'(i + 1);
    end
    return syn;
  endfunction

  // Syndromes 13..15 cannot name a bit, so the word passes through uncorrected.
  function automatic logic [7:0] hamming_decode(input logic [11:0] cw_in);
    logic [11:0] cw;
    logic [3:0]  syn;
    cw  = cw_in;
    syn = hamming_syndrome(cw_in);
    if (syn >= 4'd1 && syn <= 4'd12) cw[syn - 4'd1] = ~cw[syn - 4'd1];
    return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

  // Segment expansion to the mid-point of each quantisation step; negative when sign is 0.
  function automatic logic [12:0] alaw_decode(input logic [7:0] code);
    logic [12:0] mag;
    int unsigned sh;
    sh = {29'd0, code[6:4]};
    if (sh == 0) begin
      mag = {8'd0, code[3:0], 1'b1};
    end else begin
      mag = (13'd1 << (sh + 4)) + ({9'd0, code[3:0]} << sh) + (13'd1 << (sh - 1));
    end
    return code[7] ? mag : 13'(-mag);
  endfunction

endpackage

// File: rtl/top_fsk_receiver.sv
// Frame synchroniser: hunts for header plus clean codeword, then checks every 16th bit.
module top_fsk_receiver
  import top_pkg::*;
#(
  parameter logic [3:0] HEADER = 4'd6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        receive_fsk_data,
  output logic        r_fsk_data,
  output logic [11:0] r_frame_data,
  output logic        frame_correct
);

  rx_state_e         state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [FrameW-2:0] rx_sr;
  logic [FrameW-1:0] window;
  logic [11:0]       frame_d;
  logic              correct_d;

  assign window = {rx_sr, r_fsk_data};

  // Input retiming, window shift register and FSM state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fsk_data    <= 1'b0;
      rx_sr         <= '0;
      state_q       <= StHunt;
      bit_cnt_q     <= '0;
      r_frame_data  <= '0;
      frame_correct <= 1'b0;
    end else begin
      r_fsk_data    <= receive_fsk_data;
      rx_sr         <= window[FrameW-2:0];
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      r_frame_data  <= frame_d;
      frame_correct <= correct_d;
    end
  end

  // Hunt on every bit; once locked only the frame-aligned window is examined.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 4'd1;
    frame_d   = r_frame_data;
    correct_d = frame_correct;
    case (state_q)
      StHunt: begin
        if (window[15:12] == HEADER && hamming_syndrome(window[11:0]) == 4'd0) begin
          frame_d   = window[11:0];
          correct_d = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = StLock;
        end
      end
      StLock: begin
        if (bit_cnt_q == 4'd15) begin
          if (window[15:12] == HEADER) begin
            frame_d   = window[11:0];
            correct_d = 1'b1;
          end else begin
            correct_d = 1'b0;
            state_d   = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

endmodule

// File: rtl/top.sv
// Counter-sourced A-law/Hamming FSK transmitter plus matching receive and decode chain.
module top
  import top_pkg::*;
#(
  parameter int unsigned HEADER = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        receive_fsk_data,
  output logic [7:0]  data_in,
  output logic [7:0]  pcm_data,
  output logic [11:0] hamming_data,
  output logic [15:0] frame_data,
  output logic        fsk_data,
  output logic        r_fsk_data,
  output logic [11:0] r_frame_data,
  output logic        frame_correct,
  output logic [7:0]  r_hamming_data,
  output logic [12:0] r_pcm_data,
  output logic [7:0]  data_out
);

  localparam logic [3:0] SyncNib = 4'(HEADER);

  logic [3:0]        cnt;
  logic [FrameW-1:0] tx_sr;
  logic [12:0]       pcm_shift;

  // Frame counter; the last bit slot advances the sample and reloads the shifter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= '0;
      data_in <= '0;
      tx_sr   <= '0;
    end else begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) begin
        data_in <= data_in + 8'd1;
        tx_sr   <= frame_data;
      end else begin
        tx_sr <= {tx_sr[FrameW-2:0], 1'b0};
      end
    end
  end

  // Transmit encode chain and receive expansion are purely combinational.
  always_comb begin
    pcm_data     = alaw_encode(data_in);
    hamming_data = hamming_encode(pcm_data);
    frame_data   = {SyncNib, hamming_data};
    fsk_data     = tx_sr[FrameW-1];
    r_pcm_data   = alaw_decode(r_hamming_data);
    pcm_shift    = 13'($signed(r_pcm_data) >>> 5);
    data_out     = pcm_shift[7:0] + 8'd128;
  end

  top_fsk_receiver #(
    .HEADER(SyncNib)
  ) u_rx (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .receive_fsk_data(receive_fsk_data),
    .r_fsk_data      (r_fsk_data),
    .r_frame_data    (r_frame_data),
    .frame_correct   (frame_correct)
  );

  // Error correction one cycle behind the accepted codeword.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_hamming_data <= '0;
    else         r_hamming_data <= hamming_decode(r_frame_data);
  end

endmodule

// File: tb/tb_top.sv
// Loopback bench: driver queues cycle-stamped expectations, monitor checks them at negedges.
module tb_top;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        flip;
  logic        receive_fsk_data;
  logic [7:0]  data_in, pcm_data, r_hamming_data, data_out;
  logic [11:0] hamming_data, r_frame_data;
  logic [15:0] frame_data;
  logic        fsk_data, r_fsk_data, frame_correct;
  logic [12:0] r_pcm_data;

  localparam int KDin = 0, KPcm = 1, KHam = 2, KFrame = 3, KSer = 4, KRfr = 5;
  localparam int KRham = 6, KRpcm = 7, KDout = 8, KFc = 9, KFsk = 10, KRfsk = 11;

  typedef struct {
    int          cyc;   // -1: check while reset is asserted
    int          kind;
    logic [15:0] exp;
  } exp_t;

  typedef struct {
    int          d;
    logic [7:0]  pcm;
    logic [11:0] ham;
    logic [11:0] rfr;
    logic [12:0] rpcm;
    logic [7:0]  dout;
    int          flip_bit;
    bit          rx;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          cyc;
  int          checks = 0;
  int          failures = 0;
  bit          done = 0;
  bit          tmo = 0;
  logic [15:0] ser_sr;

  assign receive_fsk_data = fsk_data ^ flip;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  top #(.HEADER(6)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .receive_fsk_data(receive_fsk_data),
    .data_in         (data_in),
    .pcm_data        (pcm_data),
    .hamming_data    (hamming_data),
    .frame_data      (frame_data),
    .fsk_data        (fsk_data),
    .r_fsk_data      (r_fsk_data),
    .r_frame_data    (r_frame_data),
    .frame_correct   (frame_correct),
    .r_hamming_data  (r_hamming_data),
    .r_pcm_data      (r_pcm_data),
    .data_out        (data_out)
  );

  function automatic string kname(input int k);
    case (k)
      KDin:    return "data_in";
      KPcm:    return "pcm_data";
      KHam:    return "hamming_data";
      KFrame:  return "frame_data";
      KSer:    return "fsk_serial";
      KRfr:    return "r_frame_data";
      KRham:   return "r_hamming_data";
      KRpcm:   return "r_pcm_data";
      KDout:   return "data_out";
      KFc:     return "frame_correct";
      KFsk:    return "fsk_data";
      default: return "r_fsk_data";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int k);
    case (k)
      KDin:    return {8'd0, data_in};
      KPcm:    return {8'd0, pcm_data};
      KHam:    return {4'd0, hamming_data};
      KFrame:  return frame_data;
      KSer:    return ser_sr;
      KRfr:    return {4'd0, r_frame_data};
      KRham:   return {8'd0, r_hamming_data};
      KRpcm:   return {3'd0, r_pcm_data};
      KDout:   return {8'd0, data_out};
      KFc:     return {15'd0, frame_correct};
      KFsk:    return {15'd0, fsk_data};
      default: return {15'd0, r_fsk_data};
    endcase
  endfunction

  task automatic push(input int c, input int k, input logic [15:0] e);
    exp_t x;
    x.cyc  = c;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic push_reset();
    push(-1, KDin, 16'h0000);
    push(-1, KPcm, 16'h007f);
    push(-1, KHam, 16'h07ff);
    push(-1, KFrame, 16'h67ff);
    push(-1, KFsk, 16'h0000);
    push(-1, KRfsk, 16'h0000);
    push(-1, KRfr, 16'h0000);
    push(-1, KFc, 16'h0000);
    push(-1, KRham, 16'h0000);
    push(-1, KRpcm, 16'h1fff);
    push(-1, KDout, 16'h007f);
  endtask

  task automatic push_start();
    for (int c = 0; c < 16; c++) push(c, KFsk, 16'h0000);
    push(16, KFc, 16'h0000);
    push(32, KFc, 16'h0000);
  endtask

  task automatic push_vec(input int i);
    int b;
    b = 16 * vecs[i].d;
    push(b, KDin, {8'd0, 8'(vecs[i].d)});
    push(b, KPcm, {8'd0, vecs[i].pcm});
    push(b, KHam, {4'd0, vecs[i].ham});
    push(b, KFrame, {4'h6, vecs[i].ham});
    push(b + 31, KSer, {4'h6, vecs[i].ham});
    if (vecs[i].rx) begin
      push(b + 33, KRfr, {4'd0, vecs[i].rfr});
      push(b + 33, KFc, 16'h0001);
      push(b + 34, KRham, {8'd0, vecs[i].pcm});
      push(b + 34, KRpcm, {3'd0, vecs[i].rpcm});
      push(b + 34, KDout, {8'd0, vecs[i].dout});
      push(b + 34, KFc, 16'h0001);
    end else begin
      push(b + 33, KFc, 16'h0000);
      push(b + 48, KFc, 16'h0000);
    end
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc != t && guard < 20000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (cyc != t) tmo = 1;
  endtask

  // Driver
  initial begin
    sys_rst = 1'b1;
    flip    = 1'b0;
    vecs[0]  = '{0,   8'h7f, 12'h7ff, 12'h7ff, 13'h1040, 8'h02, -1, 1'b1};
    vecs[1]  = '{1,   8'h7f, 12'h7ff, 12'h7ff, 13'h1040, 8'h02, -1, 1'b1};
    vecs[2]  = '{100, 8'h5c, 12'h563, 12'h543, 13'h1c70, 8'h63, 5,  1'b1};
    vecs[3]  = '{127, 8'h10, 12'h181, 12'h181, 13'h1fdf, 8'h7e, -1, 1'b1};
    vecs[4]  = '{128, 8'h80, 12'h888, 12'h888, 13'h0001, 8'h80, -1, 1'b1};
    vecs[5]  = '{129, 8'h90, 12'h909, 12'h109, 13'h0021, 8'h81, 11, 1'b1};
    vecs[6]  = '{160, 8'he0, 12'he89, 12'he89, 13'h0420, 8'ha1, -1, 1'b1};
    vecs[7]  = '{200, 8'hf2, 12'hf11, 12'hf11, 13'h0940, 8'hca, 15, 1'b0};
    vecs[8]  = '{201, 8'hf2, 12'hf11, 12'hf11, 13'h0940, 8'hca, -1, 1'b1};
    vecs[9]  = '{255, 8'hff, 12'hf77, 12'hf77, 13'h0fc0, 8'hfe, -1, 1'b1};
    vecs[10] = '{256, 8'h7f, 12'h7ff, 12'h7ff, 13'h1040, 8'h02, -1, 1'b1};
    push_reset();
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    push_start();
    for (int i = 0; i < 11; i++) push_vec(i);
    // Single-bit line faults in chosen frames (bit 15 corrupts the header).
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].flip_bit >= 0) begin
        wait_cyc(16 * vecs[i].d + 16 + (15 - vecs[i].flip_bit));
        flip = 1'b1;
        @(negedge sys_clk);
        flip = 1'b0;
      end
    end
    // Reset in the middle of a frame, then a fresh start from data_in = 0.
    wait_cyc(4150);
    push_reset();
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    push_start();
    push_vec(0);
    push_vec(1);
    wait_cyc(60);
    done = 1;
  end

  // Monitor / scoreboard
  initial begin
    ser_sr = '0;
    while (!done) begin
      @(negedge sys_clk);
      ser_sr = {ser_sr[14:0], fsk_data};
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if ((sys_rst && sb[i].cyc == -1) || (!sys_rst && sb[i].cyc == cyc)) begin
          logic [15:0] act;
          act = actual(sb[i].kind);
          checks++;
          if (act !== sb[i].exp) begin
            failures++;
            $display("FAIL %s cyc=%0d rst=%0b got=%h exp=%h", kname(sb[i].kind), sb[i].cyc,
                     sys_rst, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
    checks++;
    if (tmo) begin
      failures++;
      $display("FAIL cycle_wait got=timeout exp=reached");
    end
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL pending %s cyc=%0d got=unchecked exp=%h", kname(sb[i].kind), sb[i].cyc,
               sb[i].exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
